// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with registered read port.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   write_en, data_in  - write request and data
//   read_en            - read request
//   data_out           - registered read data (holds when no read accepted)
//   data_valid         - one-cycle strobe per accepted read
//   full, empty        - level == DEPTH / level == 0
//   almost_full        - level >= AFULL_LEVEL
//   almost_empty       - level <= AEMPTY_LEVEL
//   level              - occupancy 0..DEPTH
//   overflow/underflow - sticky rejected-write / rejected-read flags
//   clr_err            - clears the sticky flags (a same-cycle set wins)
module param_sync_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_LEVEL  = 14,
  parameter int unsigned AEMPTY_LEVEL = 2,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Status flags decode straight from the registered level.
  assign full         = (level_q == (AW+1)'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= (AW+1)'(AFULL_LEVEL));
  assign almost_empty = (level_q <= (AW+1)'(AEMPTY_LEVEL));
  assign level        = level_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses the current-cycle full/empty only; no same-cycle bypass.
  assign wr_acc = write_en & ~full;
  assign rd_acc = read_en & ~empty;

  // Next-state logic for pointers, level, read port and error flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);

    if (rd_acc) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Clear first so a same-cycle set event overrides it.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_en && full)  overflow_d  = 1'b1;
    if (read_en  && empty) underflow_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array; contents survive reset, and reset blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed + randomized bench for param_sync_fifo against
// a queue-based reference model of the FIFO behaviour.
module tb_param_sync_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  bit         m_dv = 0, m_ovf = 0, m_unf = 0;

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ":data_valid"},   32'(data_valid),   32'(m_dv));
    chk({tag, ":full"},         32'(full),         32'(n == DEPTH));
    chk({tag, ":empty"},        32'(empty),        32'(n == 0));
    chk({tag, ":almost_full"},  32'(almost_full),  32'(n >= 14));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ":level"},        32'(level),        32'(n));
    chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ":underflow"},    32'(underflow),    32'(m_unf));
  endtask

  // One clock: drive inputs, advance model by the FIFO rules, compare.
  task automatic step(input bit r, input bit we, input logic [7:0] din,
                      input bit re, input bit ce, input string tag);
    bit f, e, wacc, racc;
    rst = r; write_en = we; data_in = din; read_en = re; clr_err = ce;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      wacc = we && !f;
      racc = re && !e;
      m_dv = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(din);
      if (we && f) m_ovf = 1; else if (ce) m_ovf = 0;
      if (re && e) m_unf = 1; else if (ce) m_unf = 0;
    end
    rst = 0; write_en = 0; read_en = 0; clr_err = 0;
    check_all(tag);
  endtask

  initial begin
    int wr_cnt, rd_cnt, cyc;
    bit we, re;

    // Reset
    step(1, 0, 8'h00, 0, 0, "reset");
    step(1, 0, 8'h00, 0, 0, "reset2");
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);

    // Fill 0x00..0x0F, then an overflowing write
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0, 0, "fill");
      if (i == 13) chk("afull_at_14", 32'(almost_full), 32'd1);
      if (i == 12) chk("afull_at_13", 32'(almost_full), 32'd0);
    end
    chk("full_at_16", 32'(full), 32'd1);
    step(0, 1, 8'hAA, 0, 0, "ovf_write");
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);

    // Drain in order, then an underflowing read
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1, 0, "drain");
      chk("drain_data", 32'(data_out), 32'(i));
      chk("drain_dv", 32'(data_valid), 32'd1);
    end
    step(0, 0, 8'h00, 1, 0, "unf_read");
    chk("unf_dout_hold", 32'(data_out), 32'h0F);
    chk("unf_set", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 0, 1, "clr");

    // Simultaneous access at level 8
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h20 + i), 0, 0, "pre8");
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h40 + i), 1, 0, "rw8");
    chk("rw8_level", 32'(level), 32'd8);

    // Simultaneous access at level 16: write rejected
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h60 + i), 0, 0, "pre16");
    step(0, 1, 8'hBB, 1, 0, "rw16");
    chk("rw16_level", 32'(level), 32'd15);
    chk("rw16_ovf", 32'(overflow), 32'd1);

    // Simultaneous access at level 0: read rejected
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0, "drain0");
    step(0, 0, 8'h00, 0, 1, "clr0");
    step(0, 1, 8'hCC, 1, 0, "rw0");
    chk("rw0_level", 32'(level), 32'd1);
    chk("rw0_unf", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1, 1, "rw0_drain");
    chk("rw0_data", 32'(data_out), 32'hCC);

    // Randomized stream of 100 incrementing words, flow-controlled
    wr_cnt = 0; rd_cnt = 0; cyc = 0;
    while (rd_cnt < 100 && cyc < 3000) begin
      we = (wr_cnt < 100) && ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
      re = ($urandom_range(0, 1) == 1) && (q.size() > 0);
      if (we) wr_cnt++;
      if (re) rd_cnt++;
      step(0, we, 8'(wr_cnt - (we ? 1 : 0)), re, 0, "stream");
      if (re) chk("stream_order", 32'(data_out), 32'(rd_cnt - 1));
      chk("stream_level", 32'(level), 32'(wr_cnt - rd_cnt));
      cyc++;
    end
    chk("stream_done", 32'(rd_cnt), 32'd100);

    // Reset at level 9 with a read pending
    for (int i = 0; i < 9; i++) step(0, 1, 8'(i), 0, 0, "pre9");
    step(1, 0, 8'h00, 1, 0, "rst9");
    rst = 1; read_en = 1;
    @(posedge clk); #1;
    rst = 0; read_en = 0;
    chk("rst9_level", 32'(level), 32'd0);
    chk("rst9_empty", 32'(empty), 32'd1);
    chk("rst9_dv", 32'(data_valid), 32'd0);

    // clr_err versus a same-cycle rejected write
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0, "prefull");
    step(0, 1, 8'hEE, 0, 1, "clr_vs_set");
    chk("clr_vs_set_ovf", 32'(overflow), 32'd1);
    step(0, 0, 8'h00, 0, 1, "clr_only");
    chk("clr_only_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, the next generation of the team's 8-bit FIFO buffer. It adds configurable width and depth, full/empty and programmable almost-full/almost-empty flags, an occupancy count, a registered read port with a data-valid strobe, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and absorbs rate mismatch and bursts.

## Interface

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of storage entries; power of two, ≥4.
- AFULL_LEVEL, 14, almost_full asserts when level ≥ this value (1..DEPTH).
- AEMPTY_LEVEL, 2, almost_empty asserts when level ≤ this value (0..DEPTH-1).
- AW (derived, not overridable), log2(DEPTH).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  write request.
- data_in  in  WIDTH  write data.
- read_en  in  1  read request.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe: data_out carries a newly read word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AFULL_LEVEL.
- almost_empty  out  1  level ≤ AEMPTY_LEVEL.
- level  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

## Operation

- Storage: DEPTH × WIDTH array. Binary write and read pointers are AW bits wide and wrap modulo DEPTH. level is a separate AW+1-bit register.
- A write is accepted when write_en=1 and full=0. The word is stored at wr_ptr, and wr_ptr increments.
- A read is accepted when read_en=1 and empty=0. mem[rd_ptr] is registered into data_out, and rd_ptr increments.
- Full is decided strictly. When full=1, a write is rejected even if a read is accepted in the same cycle.
- Empty is decided strictly. When empty=1, a read is rejected even if a write is accepted in the same cycle. There is no write-through to the read port.
- Level update: +1 for an accepted write only; −1 for an accepted read only; unchanged when both or neither are accepted.
- Simultaneous read and write with 0 < level < DEPTH: both are accepted and level is unchanged.
- A rejected write (write_en & full) sets overflow. It does not modify the array, the pointers or level.
- A rejected read (read_en & empty) sets underflow. data_out holds its value and data_valid=0.
- overflow and underflow are cleared by clr_err. A set event in the same cycle takes priority over clr_err.
- data_out holds its last value when no read is accepted.
- Flags are combinational from the registered level and carry no extra pipeline stage.
- Reset values:
  - pointers and level: 0.
  - data_out: 0.
  - data_valid: 0.
  - empty: 1.
  - almost_empty: 1.
  - full: 0.
  - almost_full: 0.
  - overflow and underflow: 0.
- Array contents are not cleared by reset.
- Reset mid-operation discards all stored words. rst has priority over write_en, read_en and clr_err in the same cycle.

## Timing

- Write accepted at edge N: level, empty, full and the almost flags reflect it from edge N onward.
- Read latency: read accepted at edge N makes data_out valid and data_valid=1 after edge N, for exactly one cycle per accepted read.
- Minimum write-to-read-data latency is 2 edges. A write at edge N permits a read at edge N+1, so data_out updates at N+1.
- Throughput: one write and one read per cycle sustained, with no bubbles.
- Back-to-back reads produce consecutive data_out words with data_valid held high.
- Wrap-around of the pointers is seamless. Order is preserved across any number of wraps.

## Test plan

- Reset check: after rst, expect empty=1, almost_empty=1, full=0, almost_full=0, level=0, data_valid=0, data_out=0, overflow=0, underflow=0.
- Fill and overflow (WIDTH=8, DEPTH=16, AFULL_LEVEL=14):
  - Write 0x00..0x0F on 16 consecutive cycles.
  - almost_full rises after the 14th write; full=1 and level=16 after the 16th.
  - A 17th write of 0xAA leaves level=16 and sets overflow=1.
  - Stored contents are unchanged.
- Drain and underflow:
  - Read 16 times; data_out must be 0x00..0x0F in order, with data_valid high for 16 cycles.
  - empty=1 after the last read.
  - A further read sets underflow=1 and leaves data_out=0x0F.
- Simultaneous access:
  - At level=8, assert read and write together for 10 cycles; level must stay 8 and read data must stay in order.
  - At level=16 with read and write asserted: read accepted, write rejected, overflow=1, level=15.
  - At level=0 with read and write asserted: write accepted, underflow=1, level=1.
- Wrap-around: stream 100 incrementing words with random read_en/write_en. Read data must match a scoreboard, level must always equal writes minus reads, and no error flag may be set when the FIFO is not full or empty.
- Reset and clear:
  - Assert rst at level=9 with read_en=1; next cycle level=0, empty=1, data_valid=0.
  - clr_err together with a rejected write must leave overflow=1.
  - clr_err alone must clear overflow.
